// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder: DIRECT (valid/ready code decode) and SCAN (autonomous walk with dwell).
// Define SCAN_DECODER_ACTIVE_LOW_EN to drive y active-low (idle all ones, active bit 0).
module scan_decoder #(
  parameter int N       = 3,
  parameter int DWELL_W = 8,
  localparam int OUT_W  = 2**N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [N-1:0]       in_code,
  output logic               in_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic               y_valid,
  output logic [N-1:0]       code_out,
  output logic               wrap
);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} st_e;

  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
  localparam logic [N-1:0]     IDX_MAX = '1;

  st_e                st;
  logic [OUT_W-1:0]   y_q;
  logic [N-1:0]       idx;
  logic [N-1:0]       idx_nxt;
  logic [DWELL_W-1:0] dwell_cnt;

  assign in_ready = (st == DIRECT);
  assign idx_nxt  = idx + 1'b1;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  assign y = ~y_q;
`else
  assign y = y_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      y_q       <= '0;
      y_valid   <= 1'b0;
      code_out  <= '0;
      wrap      <= 1'b0;
      idx       <= '0;
      dwell_cnt <= '0;
    end else if (!en) begin
      st        <= IDLE;
      y_q       <= '0;
      y_valid   <= 1'b0;
      wrap      <= 1'b0;
      idx       <= '0;
      dwell_cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          y_q     <= '0;
          y_valid <= 1'b0;
          wrap    <= 1'b0;
          if (mode) begin
            st        <= SCAN;
            idx       <= '0;
            dwell_cnt <= '0;
            y_q       <= ONE;
            code_out  <= '0;
            y_valid   <= 1'b1;
          end else begin
            st <= DIRECT;
          end
        end
        DIRECT: begin
          wrap <= 1'b0;
          if (mode) begin
            // break-before-make: one idle cycle of y = 0 before scanning
            st      <= IDLE;
            y_q     <= '0;
            y_valid <= 1'b0;
          end else if (in_valid) begin
            y_q      <= ONE << in_code;
            code_out <= in_code;
            y_valid  <= 1'b1;
          end
        end
        SCAN: begin
          if (!mode) begin
            st        <= IDLE;
            y_q       <= '0;
            y_valid   <= 1'b0;
            wrap      <= 1'b0;
            idx       <= '0;
            dwell_cnt <= '0;
          end else if (dwell_cnt >= dwell) begin
            // >= so a live drop of dwell below the count advances at once
            dwell_cnt <= '0;
            idx       <= idx_nxt;
            y_q       <= ONE << idx_nxt;
            code_out  <= idx_nxt;
            wrap      <= (idx == IDX_MAX);
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            wrap      <= 1'b0;
          end
        end
        default: begin
          st      <= IDLE;
          y_q     <= '0;
          y_valid <= 1'b0;
          wrap    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (N=3, DWELL_W=8): reset, DIRECT, SCAN, live dwell, mode switch, en, reset priority.
module tb_scan_decoder;
  localparam int N = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, en, mode, in_valid, in_ready, y_valid, wrap;
  logic [N-1:0]  in_code, code_out;
  logic [DW-1:0] dwell;
  logic [7:0]    y, ylog;
  logic          mon = 1'b0;
  int            total = 0, bad = 0;

  logic [7:0] oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  scan_decoder #(.N(N), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_code(in_code), .in_ready(in_ready), .dwell(dwell), .y(y),
    .y_valid(y_valid), .code_out(code_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] phys(input logic [7:0] v);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  assign ylog = phys(y);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (mon) begin
    chk("onehot0", 32'($onehot0(ylog)), 1);
    chk("vld_oh", 32'(!y_valid || $onehot(ylog)), 1);
  end

  initial begin
    rst = 1; en = 1; mode = 0; in_valid = 0; in_code = 0; dwell = 8'd2;
    tick(); tick();
    mon = 1'b1;
    chk("rst_y", y, phys(8'h00));
    chk("rst_yv", y_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_code", code_out, 0);

    // one IDLE cycle, then DIRECT
    rst = 0;
    tick();
    chk("dir_rdy", in_ready, 1);
    chk("dir_yv0", y_valid, 0);
    chk("dir_y0", y, phys(8'h00));

    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_code = 3'(i);
      tick();
      chk("dir_y", y, phys(oh[i]));
      chk("dir_code", code_out, i);
      chk("dir_yv", y_valid, 1);
    end
    in_valid = 0;
    tick(); tick();
    chk("dir_hold", y, phys(8'h80));
    chk("dir_hold_c", code_out, 7);

    // mode switch at code 5
    in_valid = 1; in_code = 3'd5;
    tick();
    chk("sw_y5", y, phys(8'h20));
    in_valid = 0; mode = 1;
    tick();
    chk("sw_brk_y", y, phys(8'h00));
    chk("sw_brk_yv", y_valid, 0);
    chk("sw_brk_rdy", in_ready, 0);
    tick();
    chk("scan_entry", y, phys(8'h01));
    chk("scan_entry_c", code_out, 0);
    chk("scan_entry_yv", y_valid, 1);
    chk("scan_entry_wrap", wrap, 0);
    chk("scan_rdy", in_ready, 0);

    // dwell = 2: each bit held 3 cycles, wrap 24 edges after entry
    in_valid = 1; in_code = 3'd6;
    for (int t = 1; t <= 26; t++) begin
      tick();
      chk("scan_y", y, phys(oh[(t / 3) % 8]));
      chk("scan_wrap", wrap, (t == 24) ? 1 : 0);
    end
    in_valid = 0;

    // en low mid-scan clears output next cycle
    en = 0;
    tick();
    chk("en_off_y", y, phys(8'h00));
    chk("en_off_yv", y_valid, 0);
    en = 1;
    tick();
    chk("reentry", y, phys(8'h01));

    // live dwell change 10 -> 1 with dwell_cnt = 5
    dwell = 8'd10;
    for (int t = 0; t < 5; t++) tick();
    chk("live_hold", y, phys(8'h01));
    dwell = 8'd1;
    tick();
    chk("live_adv", y, phys(8'h02));
    dwell = 8'd0;
    tick();
    chk("dw0_a", y, phys(8'h04));
    tick();
    chk("dw0_b", y, phys(8'h08));
    chk("dw0_c", code_out, 3);

    // back to DIRECT, then reset concurrent with in_valid
    mode = 0;
    tick();
    chk("back_idle", y, phys(8'h00));
    tick();
    chk("back_rdy", in_ready, 1);
    in_valid = 1; in_code = 3'd3;
    tick();
    chk("dir3", y, phys(8'h08));
    rst = 1; in_code = 3'd6;
    tick();
    chk("rstw_y", y, phys(8'h00));
    chk("rstw_yv", y_valid, 0);
    rst = 0; in_valid = 0;
    tick();
    chk("rstw_nox", y, phys(8'h00));
    chk("rstw_nov", y_valid, 0);

    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
